// File: rtl/slvds_frame_rx_if.sv
// Serial line and receive-side result bus of the single-lane frame receiver.
// The master drives the line and consumes results; the slave is the receiver.
interface slvds_frame_rx_if;
   logic        sin;
   logic [15:0] word;
   logic        word_valid;
   logic        frame_err;
   logic        seq_err;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   modport master (
      output sin,
      input  word, word_valid, frame_err, seq_err, frame_cnt, err_cnt
   );

   modport slave (
      input  sin,
      output word, word_valid, frame_err, seq_err, frame_cnt, err_cnt
   );
endinterface

// File: rtl/slvds_frame_rx.sv
// Frame receiver: two start ones, 16 data bits LSB first, stop zero, idle-low gating.
// Optional sequence check (word == previous + 1) is built when SLVDS_RX_SEQCHK_EN is defined.
module slvds_frame_rx #(
   parameter int IDLE_MIN = 8
) (
   input  logic             clk,
   input  logic             rst,
   slvds_frame_rx_if.slave  bus
);

   typedef enum logic [2:0] {
      HUNT   = 3'd0,
      ARMED  = 3'd1,
      START2 = 3'd2,
      DATA   = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [5:0] IDLE_MAX = 6'(IDLE_MIN);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [5:0]  r_idle_cnt;
   logic [5:0]  w_idle_nxt;
   logic [3:0]  r_bit_idx;
   logic [3:0]  w_bit_nxt;
   logic [15:0] r_shift;
   logic        w_good;
   logic        w_bad;
   logic        w_seq_err;
   logic        w_err_inc;

   logic [15:0] r_word;
   logic        r_word_valid;
   logic        r_frame_err;
   logic        r_seq_err;
   logic [15:0] r_frame_cnt;
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= HUNT;
         r_idle_cnt <= '0;
         r_bit_idx  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_idle_cnt <= w_idle_nxt;
         r_bit_idx  <= w_bit_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = r_idle_cnt;
      w_bit_nxt   = r_bit_idx;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      case (r_state)
         HUNT: begin
            // Any high sample restarts the quiet-line requirement.
            if (bus.sin) begin
               w_idle_nxt = '0;
            end else begin
               if (r_idle_cnt != IDLE_MAX)
                  w_idle_nxt = r_idle_cnt + 6'd1;
               if (w_idle_nxt == IDLE_MAX)
                  w_state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (bus.sin)
               w_state_nxt = START2;
         end
         START2: begin
            if (bus.sin) begin
               w_state_nxt = DATA;
               w_bit_nxt   = '0;
            end else begin
               // A lone one: the low sample already counts toward idle.
               w_state_nxt = HUNT;
               w_idle_nxt  = 6'd1;
            end
         end
         DATA: begin
            w_bit_nxt = r_bit_idx + 4'd1;
            if (r_bit_idx == 4'd15)
               w_state_nxt = STOP;
         end
         STOP: begin
            w_state_nxt = HUNT;
            w_idle_nxt  = '0;
            w_good      = ~bus.sin;
            w_bad       = bus.sin;
         end
         default: begin
            w_state_nxt = HUNT;
            w_idle_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_shift <= '0;
      else if (r_state == DATA)
         r_shift[r_bit_idx] <= bus.sin;
   end

`ifdef SLVDS_RX_SEQCHK_EN
   logic [15:0] r_ref;
   logic        r_seeded;

   // Every good word reseeds the reference, even one flagged out of sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ref    <= '0;
         r_seeded <= 1'b0;
      end else if (w_good) begin
         r_ref    <= r_shift;
         r_seeded <= 1'b1;
      end
   end

   assign w_seq_err = w_good & r_seeded & (r_shift != (r_ref + 16'd1));
`else
   assign w_seq_err = 1'b0;
`endif

   assign w_err_inc = w_bad | w_seq_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word       <= '0;
         r_word_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_seq_err    <= 1'b0;
         r_frame_cnt  <= '0;
         r_err_cnt    <= '0;
      end else begin
         r_word_valid <= w_good;
         r_frame_err  <= w_bad;
         r_seq_err    <= w_seq_err;
         if (w_good) begin
            r_word      <= r_shift;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_err_inc && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign bus.word       = r_word;
   assign bus.word_valid = r_word_valid;
   assign bus.frame_err  = r_frame_err;
   assign bus.seq_err    = r_seq_err;
   assign bus.frame_cnt  = r_frame_cnt;
   assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_slvds_frame_rx.sv
// Directed frames with a scoreboard: the driver pushes expected result events,
// a negedge monitor pops and compares whenever the receiver pulses an output.
module tb_slvds_frame_rx;

   typedef struct {
      logic [15:0] word;
      logic        fe;
      logic        se;
      logic [15:0] fcnt;
      logic [15:0] ecnt;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   vectors;
   int   miscompares;
   exp_t q[$];

   logic [15:0] m_word;
   logic [15:0] m_fcnt;
   logic [15:0] m_ecnt;
   logic [15:0] m_ref;
   logic        m_seeded;

   slvds_frame_rx_if bus ();

   slvds_frame_rx #(.IDLE_MIN(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (bus.word_valid || bus.frame_err || bus.seq_err)) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", {29'd0, bus.word_valid, bus.frame_err, bus.seq_err}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("word_valid", {31'd0, bus.word_valid}, {31'd0, ~e.fe});
            chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e.fe});
            chk("seq_err", {31'd0, bus.seq_err}, {31'd0, e.se});
            chk("word", {16'd0, bus.word}, {16'd0, e.word});
            chk("frame_cnt", {16'd0, bus.frame_cnt}, {16'd0, e.fcnt});
            chk("err_cnt", {16'd0, bus.err_cnt}, {16'd0, e.ecnt});
         end
      end
   end

   task automatic tick(input logic b);
      bus.sin = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   task automatic model_reset();
      m_word = '0; m_fcnt = '0; m_ecnt = '0; m_ref = '0; m_seeded = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0);
      tick(1'b0);
      rst = 1'b0;
      model_reset();
      chk("rst_word", {16'd0, bus.word}, 32'd0);
      chk("rst_cnts", {bus.frame_cnt, bus.err_cnt}, 32'd0);
      chk("rst_pulses", {29'd0, bus.word_valid, bus.frame_err, bus.seq_err}, 32'd0);
   endtask

   task automatic send_frame(input logic [15:0] d, input logic stopb);
      exp_t e;
      int   b15;
      logic se;
      tick(1'b1);
      tick(1'b1);
      for (int i = 0; i < 16; i++) tick(d[i]);
      b15 = cyc;
      tick(stopb);
      se = 1'b0;
      if (!stopb) begin
`ifdef SLVDS_RX_SEQCHK_EN
         se = m_seeded && (d != 16'(m_ref + 16'd1));
`endif
         m_ref = d; m_seeded = 1'b1; m_word = d; m_fcnt = m_fcnt + 16'd1;
      end
      if ((stopb || se) && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
      e.word = m_word; e.fe = stopb; e.se = se;
      e.fcnt = m_fcnt; e.ecnt = m_ecnt; e.cyc = b15 + 1;
      q.push_back(e);
   endtask

   task automatic chk_state(input string name);
      chk({name, "_word"}, {16'd0, bus.word}, {16'd0, m_word});
      chk({name, "_fcnt"}, {16'd0, bus.frame_cnt}, {16'd0, m_fcnt});
      chk({name, "_ecnt"}, {16'd0, bus.err_cnt}, {16'd0, m_ecnt});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; vectors = 0; miscompares = 0;
      rst = 1'b1; bus.sin = 1'b0;
      model_reset();

      // Single frame after reset, latency checked by the monitor
      do_reset();
      idle(8);
      send_frame(16'hA5C3, 1'b0);
      idle(10);
      chk_state("a5c3");

      // Transmitter cadence: 19 frame clocks + 45 idle = 64
      do_reset();
      idle(45);
      for (int k = 1; k <= 16; k++) begin
         send_frame(16'(k), 1'b0);
         idle(45);
      end
      chk_state("seq16");
      chk("seq16_fcnt_abs", {16'd0, bus.frame_cnt}, 32'd16);
      chk("seq16_ecnt_abs", {16'd0, bus.err_cnt}, 32'd0);

      // Sequence break then recovery, and 0xFFFF -> 0x0000 wrap
      do_reset();
      idle(8);
      send_frame(16'h0005, 1'b0); idle(10);
      send_frame(16'h0007, 1'b0); idle(10);
      send_frame(16'h0008, 1'b0); idle(10);
      chk_state("seqbrk");
      send_frame(16'hFFFF, 1'b0); idle(10);
      send_frame(16'h0000, 1'b0); idle(10);
      chk_state("wrapseq");

      // Bad stop bit, then a lone one that must be ignored
      send_frame(16'h1357, 1'b1); idle(10);
      chk_state("ferr");
      tick(1'b1); tick(1'b0); idle(10);
      chk_state("lone1");
      // Start bit too early (only 4 lows after stop) is ignored as noise
      send_frame(16'h0001, 1'b0);
      tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b0);
      tick(1'b1); tick(1'b1); tick(1'b0); idle(12);
      chk_state("early");

      // Reset in the middle of data bit 7
      idle(2);
      tick(1'b1); tick(1'b1);
      for (int i = 0; i < 7; i++) tick(1'b1);
      rst = 1'b1;
      tick(1'b1);
      rst = 1'b0;
      model_reset();
      chk_state("midrst");
      idle(8);
      send_frame(16'h1234, 1'b0); idle(10);
      chk_state("postrst");

      chk("queue_drained", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/slvds_frame_rx.md
SLVDS_FRAME_RX -- requirements
Module: slvds_frame_rx

Interface
REQ-001 Parameter: IDLE_MIN, 8, consecutive low samples required before a start bit is accepted (range 2..63).
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sin  input  1  serial line, same clock domain, sampled once per clk.
REQ-005 word  output  16  last received data word, held until the next good frame.
REQ-006 word_valid  output  1  one-cycle pulse when word updates.
REQ-007 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-008 seq_err  output  1  one-cycle pulse when a good word is not previous word + 1.
REQ-009 frame_cnt  output  16  count of good frames, wraps 0xFFFF->0x0000.
REQ-010 err_cnt  output  16  count of frame_err plus seq_err events, saturates at 0xFFFF.

Function
REQ-011 Frame on sin SHALL be: start bit 1, start bit 1, data bits 0..15 LSB first, stop bit 0, then idle low.
REQ-012 States SHALL be HUNT, ARMED, START2, DATA, STOP.
REQ-013 HUNT: idle counter SHALL count consecutive sin=0 (saturating at IDLE_MIN) and reset on sin=1; go to ARMED when count reaches IDLE_MIN.
REQ-014 ARMED: sin=1 SHALL go to START2; sin=0 SHALL stay in ARMED.
REQ-015 START2: sin=1 SHALL go to DATA with bit index 0; sin=0 SHALL go to HUNT with idle count 1, and no error flag.
REQ-016 DATA: each cycle SHALL load sin into shift bit [index]; after index 15 go to STOP.
REQ-017 STOP: sin=0 SHALL be a good frame; sin=1 SHALL be a framing error; both go to HUNT with idle count 0.
REQ-018 Good frame: in the cycle after the stop sample, word SHALL take the shifted value, word_valid SHALL be 1, and frame_cnt SHALL increment.
REQ-019 Latency: word_valid SHALL assert exactly 2 clk after the cycle sin carries data bit 15.
REQ-020 Framing error: in the cycle after the stop sample, frame_err SHALL be 1, and word, word_valid and frame_cnt SHALL be unchanged.
REQ-021 With SLVDS_RX_SEQCHK_EN defined, seq_err SHALL pulse with word_valid if the new word != (previous good word + 1) mod 2^16.
REQ-022 The first good frame after reset SHALL never raise seq_err; it only seeds the reference.
REQ-023 Each good word SHALL become the new reference, including words that raised seq_err.
REQ-024 err_cnt SHALL add 1 per frame_err or seq_err pulse; frame_err and seq_err are mutually exclusive in a cycle.
REQ-025 At 0xFFFF, err_cnt SHALL hold.
REQ-026 At 0xFFFF, frame_cnt SHALL wrap.
REQ-027 Minimum frame period SHALL be 19 + IDLE_MIN clk; a start bit arriving earlier SHALL be ignored.

Reset
REQ-028 rst SHALL force HUNT with idle count 0 and clear the shift register and the reference-seeded flag.
REQ-029 rst SHALL set word=0, word_valid=0, frame_err=0, seq_err=0, frame_cnt=0, err_cnt=0.
REQ-030 rst mid-frame SHALL discard the partial frame with no pulses; reception resumes after IDLE_MIN low samples.
REQ-031 rst SHALL take priority over all other events in the same cycle.

Configuration
REQ-032 Macro SLVDS_RX_SEQCHK_EN defined: sequence check per REQ-021..REQ-023, and err_cnt counts seq_err.
REQ-033 Macro SLVDS_RX_SEQCHK_EN undefined: no reference register or comparator is built, seq_err is tied 0, and err_cnt counts frame_err only.

Verification
REQ-034 After reset, 8 low samples, then frame carrying 0xA5C3 -> word=0xA5C3, word_valid one cycle, 2 clk after bit 15, frame_cnt=1, no errors.
REQ-035 Transmitter-format frames every 64 clk carrying 0x0001..0x0010 -> 16 word_valid pulses, frame_cnt=16, seq_err never, err_cnt=0.
REQ-036 Words 0x0005 then 0x0007 (SEQCHK on) -> seq_err with second word_valid, err_cnt=1; next 0x0008 -> no error.
REQ-037 Words 0xFFFF then 0x0000 -> no seq_err.
REQ-038 Frame with stop bit 1 -> frame_err pulse, word unchanged, err_cnt+1. Lone 1 followed by 0 -> no pulses.
REQ-039 rst asserted at data bit 7 -> no pulses, counters 0; next frame sent after 8 lows -> received correctly, seq_err 0.
